command_device_core: RTL and testbench

//  Parametrised successor of the 4-bit command-controlled device: a compact instruction-driven core.
//  It fetches WIDTH-agnostic instructions from an external asynchronous ROM and executes them on a register file with carry/zero flags.

---
 rtl/command_device_core_if.sv | 43 ++++
 rtl/command_device_core.sv | 229 ++++++++++++++++++++++
 tb/tb_command_device_core.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/command_device_core_if.sv
// rtl/command_device_core_if.sv - instruction fetch and peripheral port bus bundle
interface command_device_core_if #(
    parameter int WIDTH = 4,
    parameter int PC_W  = 8,
    parameter int PW    = 3,
    parameter int IW    = 18
);
    // Program ROM fetch: asynchronous, data valid in the same cycle as the address
    logic [PC_W-1:0]  instr_addr;
    logic [IW-1:0]    instr_data;

    // Peripheral port request/acknowledge bus
    logic [PW-1:0]    port_id;
    logic [WIDTH-1:0] port_data_out;
    logic [WIDTH-1:0] port_data_in;
    logic             port_read;
    logic             port_write;
    logic             port_ack;

    // Core side
    modport master (
        output instr_addr,
        output port_id,
        output port_data_out,
        output port_read,
        output port_write,
        input  instr_data,
        input  port_data_in,
        input  port_ack
    );

    // ROM and peripheral side
    modport slave (
        input  instr_addr,
        input  port_id,
        input  port_data_out,
        input  port_read,
        input  port_write,
        output instr_data,
        output port_data_in,
        output port_ack
    );
endinterface

// File: rtl/command_device_core.sv
// rtl/command_device_core.sv - instruction-driven core with register file, C/Z flags and port handshake
module command_device_core #(
    parameter int WIDTH      = 4,
    parameter int NREGS      = 8,
    parameter int NPORTS     = 8,
    parameter int PC_W       = 8,
    parameter int IO_TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    command_device_core_if.master  bus,
    output logic                   carry_flag,
    output logic                   zero_flag,
    output logic                   io_timeout
);
    localparam int RW = $clog2(NREGS);
    localparam int PW = $clog2(NPORTS);
    localparam int K0 = (WIDTH > PC_W) ? WIDTH : PC_W;
    localparam int K  = (K0 > PW) ? K0 : PW;
    localparam int IW = 4 + 2 * RW + K;

    // Wait counter only needs to reach IO_TIMEOUT-1; with no timeout it free-runs unused
    localparam int CW = (IO_TIMEOUT < 1) ? 1 : $clog2(IO_TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'((IO_TIMEOUT == 0) ? 0 : IO_TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_ADC = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_IN  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_JZ  = 4'hE;
    localparam logic [3:0] OP_JC  = 4'hF;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_IO_WAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             timeout_q, timeout_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic [PW-1:0]    port_id_q, port_id_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [RW-1:0]    io_rd_q, io_rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Instruction fields
    logic [3:0]       op;
    logic [RW-1:0]    rd;
    logic [RW-1:0]    rs;
    logic [K-1:0]     imm;

    // ALU scratch: bit WIDTH of ext is the carry/borrow that lands in C
    logic [WIDTH:0]   ext;
    logic             alu_wr;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [PC_W-1:0]  pc_inc;

    assign {op, rd, rs, imm} = bus.instr_data[IW-1:0];

    // Next-state, datapath and handshake decisions for the fetch/execute and IO wait states
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        regs_d    = regs_q;
        c_d       = c_q;
        z_d       = z_q;
        timeout_d = timeout_q;
        read_d    = read_q;
        write_d   = write_q;
        port_id_d = port_id_q;
        dout_d    = dout_q;
        io_rd_d   = io_rd_q;
        cnt_d     = cnt_q;
        ext       = '0;
        alu_wr    = 1'b0;
        op_a      = regs_q[rd];
        op_b      = regs_q[rs];
        pc_inc    = pc_q + PC_ONE;

        case (state_q)
            S_RUN: begin
                if (enable) begin
                    pc_d = pc_inc;
                    case (op)
                        OP_LDI: regs_d[rd] = imm[WIDTH-1:0];
                        OP_MOV: regs_d[rd] = op_b;
                        OP_ADD: begin
                            ext    = {1'b0, op_a} + {1'b0, op_b};
                            alu_wr = 1'b1;
                        end
                        OP_ADC: begin
                            ext    = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, c_q};
                            alu_wr = 1'b1;
                        end
                        OP_SUB: begin
                            ext    = {1'b0, op_a} - {1'b0, op_b};
                            alu_wr = 1'b1;
                        end
                        OP_AND: begin
                            ext    = {1'b0, op_a & op_b};
                            alu_wr = 1'b1;
                        end
                        OP_OR: begin
                            ext    = {1'b0, op_a | op_b};
                            alu_wr = 1'b1;
                        end
                        OP_XOR: begin
                            ext    = {1'b0, op_a ^ op_b};
                            alu_wr = 1'b1;
                        end
                        OP_SHL: begin
                            ext    = {op_a, 1'b0};
                            alu_wr = 1'b1;
                        end
                        OP_SHR: begin
                            ext    = {op_a[0], 1'b0, op_a[WIDTH-1:1]};
                            alu_wr = 1'b1;
                        end
                        OP_IN, OP_OUT: begin
                            // pc advances only when the transfer completes or times out
                            pc_d      = pc_q;
                            state_d   = S_IO_WAIT;
                            port_id_d = imm[PW-1:0];
                            io_rd_d   = rd;
                            cnt_d     = '0;
                            read_d    = (op == OP_IN);
                            write_d   = (op == OP_OUT);
                            if (op == OP_OUT) begin
                                dout_d = op_a;
                            end
                        end
                        OP_JMP: pc_d = imm[PC_W-1:0];
                        OP_JZ:  if (z_q) pc_d = imm[PC_W-1:0];
                        OP_JC:  if (c_q) pc_d = imm[PC_W-1:0];
                        default: ;
                    endcase
                    if (alu_wr) begin
                        regs_d[rd] = ext[WIDTH-1:0];
                        c_d        = ext[WIDTH];
                        z_d        = (ext[WIDTH-1:0] == '0);
                    end
                end
            end

            S_IO_WAIT: begin
                if (bus.port_ack) begin
                    if (read_q) begin
                        regs_d[io_rd_q] = bus.port_data_in;
                        z_d             = (bus.port_data_in == '0);
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    pc_d    = pc_inc;
                    state_d = S_RUN;
                end else if ((IO_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    timeout_d = 1'b1;
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    pc_d      = pc_inc;
                    state_d   = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: state_d = S_RUN;
        endcase
    end

    // State, register file, flags and port registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_RUN;
            pc_q      <= '0;
            regs_q    <= '{default: '0};
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            timeout_q <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            port_id_q <= '0;
            dout_q    <= '0;
            io_rd_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            regs_q    <= regs_d;
            c_q       <= c_d;
            z_q       <= z_d;
            timeout_q <= timeout_d;
            read_q    <= read_d;
            write_q   <= write_d;
            port_id_q <= port_id_d;
            dout_q    <= dout_d;
            io_rd_q   <= io_rd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.instr_addr    = pc_q;
    assign bus.port_id       = port_id_q;
    assign bus.port_data_out = dout_q;
    assign bus.port_read     = read_q;
    assign bus.port_write    = write_q;
    assign carry_flag        = c_q;
    assign zero_flag         = z_q;
    assign io_timeout        = timeout_q;
endmodule

// File: tb/tb_command_device_core.sv
// tb/tb_command_device_core.sv - self-checking bench for command_device_core
module tb_command_device_core;
    localparam int WIDTH  = 4;
    localparam int NREGS  = 8;
    localparam int NPORTS = 8;
    localparam int PC_W   = 8;
    localparam int IO_TO  = 4;
    localparam int PW     = 3;
    localparam int IW     = 18;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;
    logic carry_flag, zero_flag, io_timeout;
    logic [IW-1:0] rom [256];

    command_device_core_if #(.WIDTH(WIDTH), .PC_W(PC_W), .PW(PW), .IW(IW)) bus ();

    assign bus.instr_data = rom[bus.instr_addr];

    command_device_core #(
        .WIDTH(WIDTH), .NREGS(NREGS), .NPORTS(NPORTS), .PC_W(PC_W), .IO_TIMEOUT(IO_TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .io_timeout (io_timeout)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Architectural reference state
    int m_regs [8];
    int m_pc, m_c, m_z, m_to;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs, input int imm);
        return {op[3:0], rd[2:0], rs[2:0], imm[7:0]};
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_pc"}, 32'(bus.instr_addr), m_pc);
        check({tag, "_c"}, 32'(carry_flag), m_c);
        check({tag, "_z"}, 32'(zero_flag), m_z);
        check({tag, "_to"}, 32'(io_timeout), m_to);
        check({tag, "_strobes"}, 32'({bus.port_read, bus.port_write}), 0);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc = 0; m_c = 0; m_z = 0; m_to = 0;
    endtask

    // Architectural effect of one non-IO instruction, in plain arithmetic
    task automatic m_exec(input logic [IW-1:0] ins);
        int op, rd, rs, imm, a, b, t, res, npc;
        bit wr;
        op = int'(ins[17:14]); rd = int'(ins[13:11]); rs = int'(ins[10:8]); imm = int'(ins[7:0]);
        a = m_regs[rd]; b = m_regs[rs];
        npc = (m_pc + 1) % 256;
        wr = 0; res = 0;
        case (op)
            1:  m_regs[rd] = imm % 16;
            2:  m_regs[rd] = b;
            3:  begin t = a + b;       res = t % 16; m_c = (t > 15); wr = 1; end
            4:  begin t = a + b + m_c; res = t % 16; m_c = (t > 15); wr = 1; end
            5:  begin res = (a - b + 16) % 16; m_c = (a < b); wr = 1; end
            6:  begin res = a & b; m_c = 0; wr = 1; end
            7:  begin res = a | b; m_c = 0; wr = 1; end
            8:  begin res = a ^ b; m_c = 0; wr = 1; end
            9:  begin res = (a * 2) % 16; m_c = a / 8; wr = 1; end
            10: begin res = a / 2; m_c = a % 2; wr = 1; end
            13: npc = imm;
            14: if (m_z != 0) npc = imm;
            15: if (m_c != 0) npc = imm;
            default: ;
        endcase
        if (wr) begin
            m_regs[rd] = res;
            m_z = (res == 0);
        end
        m_pc = npc;
    endtask

    task automatic step(input logic [IW-1:0] ins);
        rom[m_pc[7:0]] = ins;
        enable = 1'b1;
        tick();
        m_exec(ins);
        check_state("step");
    endtask

    task automatic stall(input int n);
        enable = 1'b0;
        rom[m_pc[7:0]] = enc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
        repeat (n) tick();
        check_state("stall");
    endtask

    // IN/OUT at current pc; ack_cyc = IO_WAIT cycle that sees ack (0 = never)
    task automatic io_op(input bit is_in, input int rd, input int port, input int ack_cyc,
                         input int din, input bit ack_at_decode);
        int hc, exp_hc;
        bit acked;
        rom[m_pc[7:0]] = enc(is_in ? 11 : 12, rd, 0, port);
        enable = 1'b1;
        bus.port_ack = ack_at_decode;
        bus.port_data_in = 4'(din);
        tick();
        bus.port_ack = 1'b0;
        check("io_read", 32'(bus.port_read), 32'(is_in));
        check("io_write", 32'(bus.port_write), 32'(!is_in));
        check("io_port_id", 32'(bus.port_id), port);
        check("io_pc_hold", 32'(bus.instr_addr), m_pc);
        if (!is_in) check("io_dout", 32'(bus.port_data_out), m_regs[rd]);
        enable = 1'($urandom_range(0, 1));
        hc = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (!(bus.port_read || bus.port_write)) break;
            hc++;
            bus.port_ack = (cyc == ack_cyc);
            tick();
            bus.port_ack = 1'b0;
        end
        acked  = (ack_cyc >= 1) && (ack_cyc <= IO_TO);
        exp_hc = acked ? ack_cyc : IO_TO;
        check("io_cycles", hc, exp_hc);
        if (acked) begin
            if (is_in) begin
                m_regs[rd] = din;
                m_z = (din == 0);
            end
        end else begin
            m_to = 1;
        end
        m_pc = (m_pc + 1) % 256;
        check_state("io_done");
        if (!is_in) check("io_dout_hold", 32'(bus.port_data_out), m_regs[rd]);
    endtask

    task automatic dump_regs();
        for (int r = 0; r < 8; r++) io_op(1'b0, r, r, 1, 0, 1'b0);
    endtask

    initial begin
        int sel, op;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        bus.port_ack = 1'b0;
        bus.port_data_in = '0;

        // Reset state
        reset = 1'b0;
        enable = 1'b0;
        tick(); tick();
        reset = 1'b1;
        m_reset();
        check_state("reset");
        check("reset_port_id", 32'(bus.port_id), 0);
        check("reset_dout", 32'(bus.port_data_out), 0);

        // 5 + 3
        step(enc(1, 1, 0, 5));
        step(enc(1, 2, 0, 3));
        step(enc(3, 1, 2, 0));
        check("add_pc3", 32'(bus.instr_addr), 3);
        check("add_c0", 32'(carry_flag), 0);
        check("add_z0", 32'(zero_flag), 0);
        io_op(1'b0, 1, 0, 1, 0, 1'b0);
        check("add_r1_8", 32'(bus.port_data_out), 8);

        // F + 1 wraps to 0 with carry, then JC taken
        step(enc(1, 1, 0, 15));
        step(enc(1, 2, 0, 1));
        step(enc(3, 1, 2, 0));
        check("wrap_c1", 32'(carry_flag), 1);
        check("wrap_z1", 32'(zero_flag), 1);
        step(enc(15, 0, 0, 8'h20));
        check("jc_pc20", 32'(bus.instr_addr), 32'h20);

        // OUT r1 to port 6, ack on third wait cycle, ack at decode ignored
        io_op(1'b0, 1, 6, 3, 0, 1'b1);
        check("out_port6", 32'(bus.port_id), 6);

        // IN r3 from port 2, data 0, minimum latency
        step(enc(1, 4, 0, 1));
        step(enc(7, 4, 4, 0));
        check("or_z0", 32'(zero_flag), 0);
        io_op(1'b1, 3, 2, 1, 0, 1'b0);
        check("in_z1", 32'(zero_flag), 1);
        io_op(1'b0, 3, 3, 1, 0, 1'b0);
        check("in_r3_0", 32'(bus.port_data_out), 0);

        // Timeout: no ack, register untouched, flag sticky
        step(enc(1, 5, 0, 9));
        io_op(1'b1, 5, 1, 0, 7, 1'b0);
        check("to_set", 32'(io_timeout), 1);
        step(enc(0, 0, 0, 0));
        check("to_sticky", 32'(io_timeout), 1);
        io_op(1'b0, 5, 0, 1, 0, 1'b0);
        check("to_r5_9", 32'(bus.port_data_out), 9);

        // pc wraps from max to 0
        step(enc(13, 0, 0, 8'hFF));
        check("jmp_ff", 32'(bus.instr_addr), 32'hFF);
        step(enc(0, 0, 0, 0));
        check("pc_wrap0", 32'(bus.instr_addr), 0);

        // Randomized mix against the reference model
        for (int it = 0; it < 400; it++) begin
            sel = $urandom_range(0, 19);
            if (sel < 2) begin
                stall($urandom_range(1, 3));
            end else if (sel < 5) begin
                io_op(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 6), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15),
                      1'($urandom_range(0, 1)));
            end else begin
                op = $urandom_range(0, 15);
                if (op == 11 || op == 12) op = 4;
                step(enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255)));
            end
        end
        dump_regs();

        // Reset in the middle of an IO wait
        rom[m_pc[7:0]] = enc(12, 1, 0, 5);
        enable = 1'b1;
        tick();
        check("mid_write_hi", 32'(bus.port_write), 1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_reset();
        check_state("mid_reset");
        check("mid_port_id", 32'(bus.port_id), 0);
        check("mid_dout", 32'(bus.port_data_out), 0);
        dump_regs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
